qpsk_symbol_mapper: RTL and testbench

//  Downstream of the board clock divider in the qpsk design. Accepts bytes over a valid/ready handshake,

---
 rtl/qpsk_symbol_mapper_pkg.sv | 37 +++
 rtl/qpsk_symbol_mapper_if.sv | 9 +
 rtl/qpsk_symbol_mapper_sym_tick.sv | 32 +++
 rtl/qpsk_symbol_mapper.sv | 144 ++++++++++++++
 tb/tb_qpsk_symbol_mapper.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/qpsk_symbol_mapper_pkg.sv
// qpsk_symbol_mapper_pkg: shared definitions for the QPSK symbol mapper.
// Holds the mapper FSM state encoding and the Gray-dibit / quadrant tables.
// The direct mapping and the differential phase increment share one table.
package qpsk_symbol_mapper_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Gray dibit -> quadrant index (also the differential phase increment).
  // 00:0, 01:1, 11:2, 10:3
  function automatic logic [1:0] dibit_to_quad(input logic [1:0] d);
    logic [1:0] q;
    case (d)
      2'b00:   q = 2'd0;
      2'b01:   q = 2'd1;
      2'b11:   q = 2'd2;
      default: q = 2'd3;
    endcase
    return q;
  endfunction

  // Quadrant -> {negate_i, negate_q}
  // 0:(+,+) 1:(-,+) 2:(-,-) 3:(+,-)
  function automatic logic [1:0] quad_signs(input logic [1:0] q);
    logic [1:0] s;
    case (q)
      2'd0:    s = 2'b00;
      2'd1:    s = 2'b10;
      2'd2:    s = 2'b11;
      default: s = 2'b01;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/qpsk_symbol_mapper_if.sv
// qpsk_symbol_mapper_if: byte valid/ready stream feeding the symbol mapper.
interface qpsk_symbol_mapper_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/qpsk_symbol_mapper_sym_tick.sv
// qpsk_sym_tick: free-running symbol-rate counter; one-cycle tick every
// CLK_DIV clocks while enabled, counter held at zero while disabled.
module qpsk_sym_tick #(
  parameter int CLK_DIV = 120
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_enable,
  output logic o_tick
);

  localparam int CW = $clog2((CLK_DIV < 2) ? 2 : CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Count 0..CLK_DIV-1 and wrap; disabling restarts the symbol period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_enable) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = i_enable && (r_cnt == LAST);

endmodule

// File: rtl/qpsk_symbol_mapper.sv
// qpsk_symbol_mapper: accepts bytes, splits each into four dibits MSB first
// and emits one QPSK I/Q symbol per symbol tick.
// Optional build macro QPSK_DIFF_EN selects differential phase encoding;
// without it the dibit is Gray-mapped directly to a quadrant.
module qpsk_symbol_mapper
  import qpsk_symbol_mapper_pkg::*;
#(
  parameter int CLK_DIV = 120,
  parameter int IQ_W    = 16,
  parameter int AMP     = 23170
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  qpsk_symbol_mapper_if.slave    s_if,
  output logic signed [IQ_W-1:0] i_out,
  output logic signed [IQ_W-1:0] q_out,
  output logic                   sym_stb,
  output logic                   busy,
  output logic                   underrun
);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("qpsk_symbol_mapper: CLK_DIV must be >= 2");
  end
  if (AMP <= 0 || longint'(AMP) > ((longint'(1) << (IQ_W - 1)) - 1)) begin : g_bad_amp
    $error("qpsk_symbol_mapper: AMP must be positive and fit in IQ_W signed");
  end

  localparam logic signed [IQ_W-1:0] P_AMP = IQ_W'(AMP);
  localparam logic signed [IQ_W-1:0] N_AMP = -P_AMP;

  state_t                 r_state;
  logic                   r_hold_full;
  logic [7:0]             r_hold;
  logic [5:0]             r_shift;
  logic [1:0]             r_dibit_cnt;
  logic signed [IQ_W-1:0] r_i;
  logic signed [IQ_W-1:0] r_q;
  logic                   r_stb;
  logic                   r_underrun;
`ifdef QPSK_DIFF_EN
  logic [1:0]             r_phase;
`endif

  logic       w_tick;
  logic       w_accept;
  logic       w_load;
  logic       w_adv;
  logic       w_emit;
  logic [1:0] w_dibit;
  logic [1:0] w_quad;
  logic [1:0] w_signs;

  qpsk_sym_tick #(.CLK_DIV(CLK_DIV)) u_sym_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_enable (enable),
    .o_tick   (w_tick)
  );

  // Ready depends only on registered state, never on the tick.
  assign s_if.s_ready = !r_hold_full;
  assign w_accept     = s_if.s_valid && !r_hold_full;

  // Decide what this tick emits: a fresh byte's first dibit, the next
  // buffered dibit, or nothing (idle zero / underrun).
  always_comb begin
    w_load  = w_tick && r_hold_full && ((r_state == ST_IDLE) || (r_dibit_cnt == 2'd0));
    w_adv   = w_tick && (r_state == ST_RUN) && (r_dibit_cnt != 2'd0);
    w_emit  = w_load || w_adv;
    w_dibit = w_load ? r_hold[7:6] : r_shift[5:4];
`ifdef QPSK_DIFF_EN
    w_quad  = r_phase + dibit_to_quad(w_dibit);
`else
    w_quad  = dibit_to_quad(w_dibit);
`endif
    w_signs = quad_signs(w_quad);
  end

  // Mapper FSM with holding/shift registers and registered I/Q outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_hold_full <= 1'b0;
      r_hold      <= '0;
      r_shift     <= '0;
      r_dibit_cnt <= '0;
      r_i         <= '0;
      r_q         <= '0;
      r_stb       <= 1'b0;
      r_underrun  <= 1'b0;
`ifdef QPSK_DIFF_EN
      r_phase     <= '0;
`endif
    end else begin
      r_stb      <= 1'b0;
      r_underrun <= 1'b0;

      // Drain first so an accept in the same cycle leaves the register full.
      if (w_load) begin
        r_hold_full <= 1'b0;
      end
      if (w_accept) begin
        r_hold_full <= 1'b1;
        r_hold      <= s_if.s_data;
      end

      if (w_emit) begin
        r_i     <= w_signs[1] ? N_AMP : P_AMP;
        r_q     <= w_signs[0] ? N_AMP : P_AMP;
        r_stb   <= 1'b1;
        r_state <= ST_RUN;
`ifdef QPSK_DIFF_EN
        r_phase <= w_quad;
`endif
        if (w_load) begin
          r_shift     <= r_hold[5:0];
          r_dibit_cnt <= 2'd1;
        end else begin
          r_shift     <= {r_shift[3:0], 2'b00};
          r_dibit_cnt <= r_dibit_cnt + 2'd1;
        end
      end else if (w_tick) begin
        r_i <= '0;
        r_q <= '0;
        if (r_state == ST_RUN) begin
          r_underrun <= 1'b1;
          r_state    <= ST_IDLE;
`ifdef QPSK_DIFF_EN
          r_phase    <= '0;
`endif
        end
      end
    end
  end

  assign i_out    = r_i;
  assign q_out    = r_q;
  assign sym_stb  = r_stb;
  assign busy     = (r_state == ST_RUN);
  assign underrun = r_underrun;

endmodule

// File: tb/tb_qpsk_symbol_mapper.sv
// Testbench for qpsk_symbol_mapper (CLK_DIV=4, AMP=100, IQ_W=16).
module tb_qpsk_symbol_mapper;

  localparam int CLK_DIV = 4;
  localparam int IQ_W    = 16;
  localparam int AMP     = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic signed [IQ_W-1:0] i_out;
  logic signed [IQ_W-1:0] q_out;
  logic sym_stb;
  logic busy;
  logic underrun;

  qpsk_symbol_mapper_if s_if ();

  qpsk_symbol_mapper #(.CLK_DIV(CLK_DIV), .IQ_W(IQ_W), .AMP(AMP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .s_if     (s_if),
    .i_out    (i_out),
    .q_out    (q_out),
    .sym_stb  (sym_stb),
    .busy     (busy),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int i;
    int q;
  } sym_t;

  sym_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_stb = 0;
  bit   expect_gap = 1'b0;
  int   m_phase = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: four symbols per byte, MSB dibit first.
  task automatic push_byte(input logic [7:0] b);
    sym_t s;
    logic [1:0] d;
    int inc_tbl[4];
    inc_tbl = '{0, 1, 3, 2};
    for (int k = 3; k >= 0; k--) begin
      d = b[2*k +: 2];
`ifdef QPSK_DIFF_EN
      m_phase = (m_phase + inc_tbl[d]) % 4;
      s.i = (m_phase == 1 || m_phase == 2) ? -AMP : AMP;
      s.q = (m_phase >= 2) ? -AMP : AMP;
`else
      s.i = d[0] ? -AMP : AMP;
      s.q = d[1] ? -AMP : AMP;
`endif
      exp_q.push_back(s);
    end
  endtask

  // Advance one clock, sample 1 ns after the edge and score any new symbol.
  task automatic cycle();
    sym_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (sym_stb === 1'b1) begin
      chk("stb_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sym_i", 32'(i_out), e.i);
        chk("sym_q", 32'(q_out), e.q);
      end
      if (expect_gap) chk("stb_spacing", cyc - last_stb, CLK_DIV);
      last_stb   = cyc;
      expect_gap = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit hold_valid);
    bit done = 1'b0;
    bit rdy;
    s_if.s_data  = b;
    s_if.s_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      rdy = s_if.s_ready;
      cycle();
      if (rdy) begin
        done = 1'b1;
        push_byte(b);
        chk("ready_low_after_accept", 32'(s_if.s_ready), 0);
      end
    end
    chk("byte_accepted", 32'(done), 1);
    if (!hold_valid) s_if.s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) cycle();
    chk("symbols_drained", exp_q.size(), 0);
  endtask

  task automatic wait_underrun();
    bit seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      cycle();
      if (underrun === 1'b1) seen = 1'b1;
    end
    chk("underrun_seen", 32'(seen), 1);
    chk("underrun_delay", cyc - last_stb, CLK_DIV);
    chk("underrun_i_zero", 32'(i_out), 0);
    chk("underrun_q_zero", 32'(q_out), 0);
    chk("underrun_busy_low", 32'(busy), 0);
    cycle();
    chk("underrun_one_cycle", 32'(underrun), 0);
    m_phase    = 0;
    expect_gap = 1'b0;
  endtask

  initial begin
    logic signed [IQ_W-1:0] frz_i;
    logic signed [IQ_W-1:0] frz_q;
    logic [7:0] rb;

    s_if.s_data  = 8'h00;
    s_if.s_valid = 1'b0;
    rst_n  = 1'b0;
    enable = 1'b1;

    // Reset state
    repeat (3) cycle();
    chk("rst_i", 32'(i_out), 0);
    chk("rst_q", 32'(q_out), 0);
    chk("rst_ready", 32'(s_if.s_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_stb", 32'(sym_stb), 0);
    chk("rst_underrun", 32'(underrun), 0);
    rst_n = 1'b1;
    cycle();

    // Single byte 0x1B, then idle into underrun
    send_byte(8'h1B, 1'b0);
    for (int k = 0; k < 50 && exp_q.size() == 4; k++) cycle();
    chk("busy_in_run", 32'(busy), 1);
    wait_drain();
    wait_underrun();

    // Back-to-back bytes held valid
    send_byte(8'hFF, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h55, 1'b0);
    wait_drain();
    wait_underrun();

    // Standalone 0x55 (phase starts fresh in differential builds)
    send_byte(8'h55, 1'b0);
    wait_drain();
    wait_underrun();

    // Randomized back-to-back burst
    for (int n = 0; n < 12; n++) begin
      rb = 8'($urandom);
      send_byte(rb, n != 11);
    end
    wait_drain();
    wait_underrun();

    // enable low mid-byte freezes symbol and dibit position
    send_byte(8'h2D, 1'b0);
    for (int k = 0; k < 50 && exp_q.size() > 2; k++) cycle();
    frz_i  = i_out;
    frz_q  = q_out;
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("frozen_stb", 32'(sym_stb), 0);
      chk("frozen_i", 32'(i_out), 32'(frz_i));
      chk("frozen_q", 32'(q_out), 32'(frz_q));
    end
    chk("frozen_busy", 32'(busy), 1);
    enable     = 1'b1;
    expect_gap = 1'b0;
    wait_drain();
    wait_underrun();

    // Reset in the middle of 0xC3 discards the rest of the byte
    send_byte(8'hC3, 1'b0);
    for (int k = 0; k < 50 && exp_q.size() > 2; k++) cycle();
    rst_n = 1'b0;
    cycle();
    chk("midrst_i", 32'(i_out), 0);
    chk("midrst_q", 32'(q_out), 0);
    chk("midrst_ready", 32'(s_if.s_ready), 1);
    chk("midrst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    exp_q.delete();
    m_phase    = 0;
    expect_gap = 1'b0;
    rb = 8'($urandom);
    send_byte(rb, 1'b0);
    wait_drain();
    wait_underrun();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
